// File: rtl/or16_accum.sv
// or16_accum -- ORs WORDS consecutive 16-bit words into one frame result.
// Words and results use valid/ready handshakes. A completed result is held in
// DONE until downstream takes it. A new frame may start on the same edge the
// result is released.
// Optional feature: define OR16_ACCUM_ZERO_EN to add the registered out_zero
// flag, which is set when the frame result is all-zero.
// flush is the synchronous abort. It discards the partial frame and any pending result.
module or16_accum #(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef OR16_ACCUM_ZERO_EN
    output logic        out_zero,
`endif
    output logic [15:0] out
);

    // Index of the word that completes a frame.
    localparam logic [7:0] LAST = 8'(WORDS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t      state_r;
    logic [15:0] acc_r;
    logic [7:0]  count_r;
    logic [15:0] out_r;
    logic        out_valid_r;

    logic        in_ready_s;
    logic        accept_s;
    logic        load_s;
    logic [15:0] result_s;

    // All-zero detector for a frame result.
    function automatic logic is_zero(input logic [15:0] v);
        return (v == 16'h0000);
    endfunction

    // Ready while collecting, or while the held result leaves this cycle; never during flush.
    always_comb begin
        in_ready_s = 1'b0;
        if (flush) begin
            in_ready_s = 1'b0;
        end else if ((state_r == ACCUM) || out_ready) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign in_ready = in_ready_s;
    assign accept_s = in_valid & in_ready_s;

    // Decide whether a result loads this edge, and what that result is.
    // In DONE, a load happens only for single-word frames that restart back-to-back.
    always_comb begin
        load_s   = 1'b0;
        result_s = 16'h0000;
        if (state_r == ACCUM) begin
            load_s   = accept_s & (count_r == LAST);
            result_s = acc_r | in_data;
        end else begin
            load_s   = accept_s & out_ready & (WORDS == 1);
            result_s = in_data;
        end
    end

    // Frame FSM: accumulation, count, state and result-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ACCUM;
            acc_r       <= 16'h0000;
            count_r     <= 8'd0;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            state_r     <= ACCUM;
            acc_r       <= 16'h0000;
            count_r     <= 8'd0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        if (count_r == LAST) begin
                            acc_r       <= 16'h0000;
                            count_r     <= 8'd0;
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            acc_r   <= acc_r | in_data;
                            count_r <= count_r + 8'd1;
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (accept_s) begin
                            if (WORDS == 1) begin
                                // The new word is already a complete frame, so stay in DONE.
                                state_r     <= DONE;
                                out_valid_r <= 1'b1;
                            end else begin
                                acc_r       <= in_data;
                                count_r     <= 8'd1;
                                state_r     <= ACCUM;
                                out_valid_r <= 1'b0;
                            end
                        end else begin
                            state_r     <= ACCUM;
                            out_valid_r <= 1'b0;
                        end
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= ACCUM;
                    acc_r       <= 16'h0000;
                    count_r     <= 8'd0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Result register: keeps its value after release. Only out_valid qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= 16'h0000;
        end else if (load_s) begin
            out_r <= result_s;
        end else begin
            out_r <= out_r;
        end
    end

`ifdef OR16_ACCUM_ZERO_EN
    logic out_zero_r;

    // Zero flag loads with the result. It is cleared by reset and by flush, like out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero_r <= 1'b0;
        end else if (flush) begin
            out_zero_r <= 1'b0;
        end else if (load_s) begin
            out_zero_r <= is_zero(result_s);
        end else begin
            out_zero_r <= out_zero_r;
        end
    end

    assign out_zero = out_zero_r;
`endif

    assign out       = out_r;
    assign out_valid = out_valid_r;

endmodule
